serial_pattern_detector: RTL

//  Consumes the registered serial bit stream from the single-bit D flip-flop stage (its q drives bit_in).

---
 rtl/serial_pattern_detector.sv | 74 +++++++
 1 files changed

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts accepted bits into a history register, pulses match on
// a PATTERN hit and keeps a saturating, clearable match count.
module serial_pattern_detector #(
  parameter int unsigned PATTERN_LEN = 4,
  parameter logic [31:0] PATTERN     = 32'b1011,
  parameter bit          OVERLAP     = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned            FW      = $clog2(PATTERN_LEN + 1);
  localparam logic [PATTERN_LEN-1:0] PAT     = PATTERN[PATTERN_LEN-1:0];
  localparam logic [FW-1:0]          FULL    = FW'(PATTERN_LEN);
  localparam logic [CNT_W-1:0]       CNT_MAX = '1;

  typedef enum logic {FILL, DETECT} state_t;

  state_t                 state;
  logic [FW-1:0]          fill_cnt;
  logic [PATTERN_LEN-1:0] history;
  logic [PATTERN_LEN-1:0] hist_nxt;
  logic [FW-1:0]          fill_nxt;
  logic                   armed;
  logic                   hit;

  // The bit that completes the fill is compared in the same cycle, hence armed looks ahead.
  always_comb begin
    hist_nxt = {history[PATTERN_LEN-2:0], bit_in};
    fill_nxt = fill_cnt + 1'b1;
    armed    = (state == DETECT) || (fill_nxt == FULL);
    hit      = bit_valid && armed && (hist_nxt == PAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      fill_cnt    <= '0;
      history     <= '0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match <= hit;
      if (bit_valid) begin
        history <= hist_nxt;
        if (state == FILL) begin
          fill_cnt <= fill_nxt;
          if (fill_nxt == FULL) state <= DETECT;
        end
        if (hit && !OVERLAP) begin
          fill_cnt <= '0;
          state    <= FILL;
        end
      end
      // Clear wins over a coincident increment; the match pulse is unaffected.
      if (clear_count) begin
        match_count <= '0;
        count_sat   <= 1'b0;
      end else if (hit && match_count != CNT_MAX) begin
        match_count <= match_count + 1'b1;
        if (match_count == CNT_MAX - 1'b1) count_sat <= 1'b1;
      end
    end
  end

endmodule
